maze_fsm: RTL and testbench

Parametrised dungeon-navigation state machine for the room-game family. It tracks the player's position on a COLS×ROWS grid of rooms with a configurable wall map, and latches sword pickup in a designated room. Entering the dragon room resolves to win or death, and an optional move budget kills the player on exhaustion. It replaces the fixed four-room hand-written machine and drives the same display/status logic (`sw`, `win`, `d`).

---
 rtl/maze_fsm_if.sv | 17 +
 rtl/maze_fsm.sv | 99 +++++++++
 tb/tb_maze_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/maze_fsm_if.sv
// Direction requests and status outputs of the dungeon-navigation FSM.
// Player/driver side is master, the FSM is the slave.
interface maze_fsm_if #(
    parameter int N  = 6,
    parameter int RW = 3
) ();
    logic          n, s, e, w;
    logic [RW-1:0] room;
    logic [N-1:0]  room_oh;
    logic          sw, win, d, bump;
    logic [7:0]    moves;

    modport master (output n, s, e, w,
                    input  room, room_oh, sw, win, d, bump, moves);
    modport slave  (input  n, s, e, w,
                    output room, room_oh, sw, win, d, bump, moves);
endinterface

// File: rtl/maze_fsm.sv
// Grid dungeon navigation: walls, sword pickup, dragon encounter and
// an optional move budget. All status outputs come straight from registers.
module maze_fsm #(
    parameter int              COLS        = 3,
    parameter int              ROWS        = 2,
    parameter logic [4*COLS*ROWS-1:0] WALLS = '0,
    parameter int              START_ROOM  = 0,
    parameter int              SWORD_ROOM  = 2,
    parameter int              DRAGON_ROOM = 5,
    parameter int              MOVE_LIMIT  = 0
) (
    input logic        clk,
    input logic        reset,
    maze_fsm_if.slave  bus
);
    localparam int N  = COLS * ROWS;
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    if (DRAGON_ROOM == START_ROOM) begin : g_bad_dragon
        $error("maze_fsm: DRAGON_ROOM must differ from START_ROOM");
    end

    typedef enum logic [1:0] {EXPLORE, ENCOUNTER, WIN, DEAD} state_t;

    state_t        state, nxt_state;
    logic [RW-1:0] room, nxt_room;
    logic [N-1:0]  room_oh, nxt_oh;
    logic          sw, nxt_sw;
    logic          bump, nxt_bump;
    logic [7:0]    moves, nxt_moves;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EXPLORE;
            room    <= RW'(START_ROOM);
            room_oh <= N'(1) << START_ROOM;
            sw      <= (START_ROOM == SWORD_ROOM);
            bump    <= 1'b0;
            moves   <= 8'd0;
        end else begin
            state   <= nxt_state;
            room    <= nxt_room;
            room_oh <= nxt_oh;
            sw      <= nxt_sw;
            bump    <= nxt_bump;
            moves   <= nxt_moves;
        end
    end

    always_comb begin
        int         r, dest;
        logic       one, blk;
        logic [3:0] wl;
        nxt_state = state;
        nxt_room  = room;
        nxt_oh    = room_oh;
        nxt_sw    = sw;
        nxt_bump  = 1'b0;
        nxt_moves = moves;
        r    = int'(room);
        wl   = 4'(WALLS >> (4 * r));
        one  = ({3'b000, bus.n} + {3'b000, bus.s} + {3'b000, bus.e} + {3'b000, bus.w}) == 4'd1;
        blk  = 1'b0;
        dest = r;
        if (bus.n)      begin blk = wl[0] | (r < COLS);              dest = r - COLS; end
        else if (bus.s) begin blk = wl[2] | (r >= N - COLS);         dest = r + COLS; end
        else if (bus.e) begin blk = wl[1] | (r % COLS == COLS - 1);  dest = r + 1;    end
        else if (bus.w) begin blk = wl[3] | (r % COLS == 0);         dest = r - 1;    end
        case (state)
            EXPLORE: begin
                if (one && blk) begin
                    nxt_bump = 1'b1;
                end else if (one) begin
                    nxt_room  = RW'(dest);
                    nxt_oh    = N'(1) << dest;
                    nxt_sw    = sw | (dest == SWORD_ROOM);
                    nxt_moves = (moves == 8'hFF) ? moves : moves + 8'd1;
                    // The dragon takes precedence over running out of moves.
                    if (dest == DRAGON_ROOM)
                        nxt_state = ENCOUNTER;
                    else if (MOVE_LIMIT != 0 && int'(nxt_moves) == MOVE_LIMIT)
                        nxt_state = DEAD;
                end
            end
            ENCOUNTER: nxt_state = sw ? WIN : DEAD;
            default:   nxt_state = state;
        endcase
    end

    always_comb begin
        bus.room    = room;
        bus.room_oh = room_oh;
        bus.sw      = sw;
        bus.bump    = bump;
        bus.moves   = moves;
        bus.win     = (state == WIN);
        bus.d       = (state == DEAD);
    end
endmodule

// File: tb/tb_maze_fsm.sv
// Directed bench: five maze_fsm variants share one stimulus stream; each
// phase checks the variant whose parameters it exercises.
module tb_maze_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    maze_fsm_if #(.N(6), .RW(3)) b0 ();
    maze_fsm_if #(.N(6), .RW(3)) b1 ();
    maze_fsm_if #(.N(6), .RW(3)) b2 ();
    maze_fsm_if #(.N(6), .RW(3)) b3 ();
    maze_fsm_if #(.N(6), .RW(3)) b4 ();

    assign {b0.n, b0.s, b0.e, b0.w} = {n, s, e, w};
    assign {b1.n, b1.s, b1.e, b1.w} = {n, s, e, w};
    assign {b2.n, b2.s, b2.e, b2.w} = {n, s, e, w};
    assign {b3.n, b3.s, b3.e, b3.w} = {n, s, e, w};
    assign {b4.n, b4.s, b4.e, b4.w} = {n, s, e, w};

    maze_fsm                            u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    maze_fsm #(.WALLS(24'h000020))      u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    maze_fsm #(.MOVE_LIMIT(2))          u2 (.clk(clk), .reset(reset), .bus(b2.slave));
    maze_fsm #(.MOVE_LIMIT(3))          u3 (.clk(clk), .reset(reset), .bus(b3.slave));
    maze_fsm #(.START_ROOM(2))          u4 (.clk(clk), .reset(reset), .bus(b4.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dir = {n,s,e,w}
    task automatic step(input logic [3:0] dir);
        {n, s, e, w} = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000);
        reset = 1'b0;
    endtask

    localparam logic [3:0] NO = 4'b0000, DN = 4'b1000, DS = 4'b0100,
                           DE = 4'b0010, DW = 4'b0001;

    initial begin
        // Reset state
        do_reset();
        chk("rst_room", 32'(b0.room), 0);
        chk("rst_oh", 32'(b0.room_oh), 32'h01);
        chk("rst_sw", 32'(b0.sw), 0);
        chk("rst_win_d", 32'({b0.win, b0.d}), 0);
        chk("rst_bump", 32'(b0.bump), 0);
        chk("rst_moves", 32'(b0.moves), 0);
        chk("start2_room", 32'(b4.room), 2);
        chk("start2_oh", 32'(b4.room_oh), 32'h04);
        chk("start2_sw", 32'(b4.sw), 1);

        // Winning path e,e,s (also wall map and MOVE_LIMIT=3)
        step(DE);
        chk("win_r1", 32'(b0.room), 1);
        chk("win_m1", 32'(b0.moves), 1);
        chk("win_sw1", 32'(b0.sw), 0);
        chk("wall_r1", 32'(b1.room), 1);
        step(DE);
        chk("win_r2", 32'(b0.room), 2);
        chk("win_sw2", 32'(b0.sw), 1);
        chk("wall_bump", 32'(b1.bump), 1);
        chk("wall_room", 32'(b1.room), 1);
        chk("wall_moves", 32'(b1.moves), 1);
        step(DS);
        chk("win_r5", 32'(b0.room), 5);
        chk("win_oh5", 32'(b0.room_oh), 32'h20);
        chk("win_m3", 32'(b0.moves), 3);
        chk("win_enc", 32'({b0.win, b0.d}), 0);
        chk("wall_s_room", 32'(b1.room), 4);
        chk("wall_s_bump", 32'(b1.bump), 0);
        chk("lim3_enc", 32'({b3.win, b3.d}), 0);
        step(NO);
        chk("win_win", 32'(b0.win), 1);
        chk("win_d", 32'(b0.d), 0);
        chk("lim3_win", 32'({b3.win, b3.d}), 32'b10);
        step(DN);
        chk("win_frz_room", 32'(b0.room), 5);
        chk("win_frz_moves", 32'(b0.moves), 3);
        chk("win_frz_bump", 32'(b0.bump), 0);

        // Reset out of WIN
        do_reset();
        chk("rstwin_room", 32'(b0.room), 0);
        chk("rstwin_all", 32'({b0.sw, b0.win, b0.d, b0.moves}), 0);

        // Death path s,e,e
        step(DS);
        chk("die_r3", 32'(b0.room), 3);
        step(DE);
        chk("die_r4", 32'(b0.room), 4);
        step(DE);
        chk("die_r5", 32'(b0.room), 5);
        chk("die_sw", 32'(b0.sw), 0);
        chk("die_enc", 32'({b0.win, b0.d}), 0);
        step(NO);
        chk("die_d", 32'({b0.win, b0.d}), 32'b01);

        // Edges and invalid input
        do_reset();
        step(DN);
        chk("edge_bump", 32'(b0.bump), 1);
        chk("edge_room", 32'(b0.room), 0);
        chk("edge_moves", 32'(b0.moves), 0);
        step(DN);
        chk("edge_bump_hold", 32'(b0.bump), 1);
        step(DN | DE);
        chk("multi_bump", 32'(b0.bump), 0);
        chk("multi_room", 32'(b0.room), 0);
        step(NO);
        chk("none_room", 32'(b0.room), 0);
        chk("none_moves", 32'(b0.moves), 0);
        step(DW);
        chk("west_edge_bump", 32'(b0.bump), 1);

        // Move budget MOVE_LIMIT=2: e,w
        do_reset();
        step(DE);
        chk("lim2_r1", 32'(b2.room), 1);
        chk("lim2_alive", 32'(b2.d), 0);
        step(DW);
        chk("lim2_dead", 32'({b2.win, b2.d}), 32'b01);
        chk("lim2_room", 32'(b2.room), 0);
        chk("lim2_moves", 32'(b2.moves), 2);
        step(DE);
        chk("lim2_frz_room", 32'(b2.room), 0);
        chk("lim2_frz_moves", 32'(b2.moves), 2);
        chk("lim2_frz_bump", 32'(b2.bump), 0);

        // Reset during ENCOUNTER
        do_reset();
        step(DE);
        step(DE);
        step(DS);
        chk("enc_pre", 32'(b0.room), 5);
        do_reset();
        chk("rstenc_room", 32'(b0.room), 0);
        chk("rstenc_oh", 32'(b0.room_oh), 32'h01);
        chk("rstenc_all", 32'({b0.sw, b0.win, b0.d, b0.moves}), 0);
        step(NO);
        chk("rstenc_stay", 32'({b0.win, b0.d}), 0);
        chk("start2_sw_again", 32'(b4.sw), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
